// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state type, sizes and key byte helper for the RC4 key schedule
package rc4_pkg;

  localparam int S_DEP     = 256;
  localparam int MSG_WIDTH = 8;
  localparam int KEY_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT   = 4'd1,
    RD_SI  = 4'd2,
    CAP_SI = 4'd3,
    RD_SJ  = 4'd4,
    CAP_SJ = 4'd5,
    WR_I   = 4'd6,
    WR_J   = 4'd7,
    NEXT   = 4'd8,
    DONE   = 4'd9
  } state_t;

  // Byte 0 of the key sits in the most significant eight bits of the vector
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key, input int unsigned n);
    return key[8*(KEY_BYTES-1-n) +: 8];
  endfunction

endpackage

// File: rtl/key_schedule_fsm_if.sv
// rtl/key_schedule_fsm_if.sv - single-port S-memory bus between the key schedule and the RAM
interface key_schedule_fsm_if #(
  parameter int MSG_WIDTH = 8
);

  logic [MSG_WIDTH-1:0] mem_addr;
  logic [MSG_WIDTH-1:0] mem_data;
  logic                 mem_wren;
  logic [MSG_WIDTH-1:0] mem_q;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_wren,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_wren,
    output mem_q
  );

endinterface

// File: rtl/key_schedule_fsm.sv
// rtl/key_schedule_fsm.sv - RC4 key scheduling state machine driving an external S-memory
module key_schedule_fsm #(
  parameter int S_DEP     = rc4_pkg::S_DEP,
  parameter int MSG_WIDTH = rc4_pkg::MSG_WIDTH,
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  key_schedule_fsm_if.master     mem,
  output logic                   busy,
  output logic                   done
);

  import rc4_pkg::*;

  localparam int                   KC_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [MSG_WIDTH-1:0] LAST_I  = MSG_WIDTH'(S_DEP - 1);
  localparam logic [KC_W-1:0]      LAST_KC = KC_W'(KEY_BYTES - 1);

  state_t               state;
  logic [MSG_WIDTH-1:0] i;
  logic [MSG_WIDTH-1:0] j;
  logic [MSG_WIDTH-1:0] si;
  logic [MSG_WIDTH-1:0] sj;
  logic [KC_W-1:0]      kc;

  logic [MSG_WIDTH-1:0] i_inc;
  logic [MSG_WIDTH-1:0] j_sum;
  logic [KC_W-1:0]      kc_inc;

  // kc mirrors i mod KEY_BYTES so the key byte is picked without a divider
  assign i_inc  = i + 1'b1;
  assign kc_inc = (kc == LAST_KC) ? '0 : kc + 1'b1;
  assign j_sum  = j + mem.mem_q + MSG_WIDTH'(key_byte(secret_key, 32'(kc)));

  // Sequencing of the init pass and the seven-cycle swap loop, with registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= INIT;
            i     <= '0;
            j     <= '0;
            kc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        INIT: begin
          if (i == LAST_I) begin
            state <= RD_SI;
            i     <= '0;
            kc    <= '0;
          end else begin
            i  <= i_inc;
            kc <= kc_inc;
          end
        end
        RD_SI:  state <= CAP_SI;
        CAP_SI: begin
          si    <= mem.mem_q;
          j     <= j_sum;
          state <= RD_SJ;
        end
        RD_SJ:  state <= CAP_SJ;
        CAP_SJ: begin
          sj    <= mem.mem_q;
          state <= WR_I;
        end
        WR_I:   state <= WR_J;
        WR_J:   state <= NEXT;
        NEXT: begin
          if (i == LAST_I) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i     <= i_inc;
            kc    <= kc_inc;
            state <= RD_SI;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port is a pure function of the current state and the i/j/si/sj registers
  always_comb begin
    mem.mem_addr = '0;
    mem.mem_data = '0;
    mem.mem_wren = 1'b0;
    case (state)
      INIT: begin
        mem.mem_addr = i;
        mem.mem_data = i;
        mem.mem_wren = 1'b1;
      end
      RD_SI, CAP_SI: mem.mem_addr = i;
      RD_SJ, CAP_SJ: mem.mem_addr = j;
      WR_I: begin
        mem.mem_addr = i;
        mem.mem_data = sj;
        mem.mem_wren = 1'b1;
      end
      WR_J: begin
        mem.mem_addr = j;
        mem.mem_data = si;
        mem.mem_wren = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_schedule_fsm.sv
// tb/tb_key_schedule_fsm.sv - directed self-checking bench for the RC4 key schedule FSM
module tb_key_schedule_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ram   [256];
  logic [7:0] exp_s [256];
  logic [7:0] jhist [256];

  key_schedule_fsm_if #(.MSG_WIDTH(8)) mb ();

  key_schedule_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .mem        (mb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-before-write, one-cycle read latency
  always @(posedge clk) begin
    if (mb.mem_wren) ram[mb.mem_addr] <= mb.mem_data;
    mb.mem_q <= ram[mb.mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Textbook RC4 KSA; also records j after each i for the read-address scoreboard
  task automatic model_ksa(input logic [23:0] key);
    int         jj;
    logic [7:0] t;
    logic [7:0] kb;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      kb = key[23 - 8*(k % 3) -: 8];
      jj = (jj + int'(exp_s[k]) + int'(kb)) % 256;
      jhist[k] = 8'(jj);
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (ram[k] !== exp_s[k]) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    if (bad != 0) $display("note: %s first differing S index %0d got %0h want %0h", tag, first, ram[first], exp_s[first]);
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_wren"}, 32'(mb.mem_wren), 32'd0);
    chk({tag, "_addr"}, 32'(mb.mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(mb.mem_data), 32'd0);
  endtask

  // Runs from the first INIT cycle (n=0) until done or the cycle budget expires
  task automatic wait_done(input bit tog, input bit chk_ij, output int n, output int wr);
    int idx;
    n  = 0;
    wr = 0;
    while (!done && n < 4000) begin
      if (mb.mem_wren) wr++;
      if (n == 256) begin
        idx = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== 8'(k)) idx++;
        chk("init_identity", 32'(idx), 32'd0);
      end
      if (chk_ij && n == 263) chk("i_eq_j_s0", 32'(ram[0]), 32'd0);
      if (n >= 256 && n < 2048 && (n - 256) % 7 == 0)
        chk("rd_si_addr", 32'(mb.mem_addr), 32'((n - 256) / 7));
      if (n >= 256 && n < 2048 && (n - 256) % 7 == 2)
        chk("rd_sj_addr", 32'(mb.mem_addr), 32'(jhist[(n - 256) / 7]));
      if (tog) start = (n >= 300 && n < 2040) ? n[0] : 1'b1;
      step();
      n++;
    end
  endtask

  task automatic check_first_init(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_wren"}, 32'(mb.mem_wren), 32'd1);
    chk({tag, "_addr"}, 32'(mb.mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(mb.mem_data), 32'd0);
  endtask

  initial begin
    int n;
    int wr;

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'h000000;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("idle_no_start");

    // Key 000000 from a start pulse
    model_ksa(24'h000000);
    start = 1'b1;
    step();
    start = 1'b0;
    check_first_init("k0_init");
    wait_done(1'b0, 1'b1, n, wr);
    chk("k0_latency", 32'(n), 32'd2048);
    chk("k0_wren_cycles", 32'(wr), 32'd768);
    chk("k0_done", 32'(done), 32'd1);
    chk("k0_busy_done", 32'(busy), 32'd0);
    check_mem("k0_final_s");
    step();
    step();
    chk("done_hold", 32'(done), 32'd1);
    chk("done_hold_wren", 32'(mb.mem_wren), 32'd0);

    // Key 000249 restarted from DONE; byte 0 of zero forces i==j at i=0
    secret_key = 24'h000249;
    model_ksa(24'h000249);
    start = 1'b1;
    step();
    start = 1'b0;
    check_first_init("k249_init");
    wait_done(1'b0, 1'b1, n, wr);
    chk("k249_latency", 32'(n), 32'd2048);
    chk("k249_wren_cycles", 32'(wr), 32'd768);
    check_mem("k249_final_s");

    // Reset during INIT
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("mid_init_addr", 32'(mb.mem_addr), 32'd100);
    chk("mid_init_wren", 32'(mb.mem_wren), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst_init");
    step();
    check_idle("rst_init_hold");

    // Reset during WR_J of i=106, with start also high to show reset wins
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 1003; k++) step();
    chk("wr_j_wren", 32'(mb.mem_wren), 32'd1);
    chk("wr_j_addr", 32'(mb.mem_addr), 32'(jhist[106]));
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check_idle("rst_wrj");

    // Restart with the same key after the aborted runs
    start = 1'b1;
    step();
    start = 1'b0;
    check_first_init("rerun_init");
    wait_done(1'b0, 1'b1, n, wr);
    chk("rerun_latency", 32'(n), 32'd2048);
    check_mem("rerun_final_s");

    // Start held high and toggled while busy: no restart before DONE
    reset = 1'b1;
    step();
    reset = 1'b0;
    secret_key = 24'h000000;
    model_ksa(24'h000000);
    start = 1'b1;
    step();
    check_first_init("hold_init");
    wait_done(1'b1, 1'b1, n, wr);
    chk("hold_latency", 32'(n), 32'd2048);
    chk("hold_wren_cycles", 32'(wr), 32'd768);
    check_mem("hold_final_s");

    // DONE with start still high and a new key: immediate rerun
    secret_key = 24'hFFFFFF;
    model_ksa(24'hFFFFFF);
    step();
    start = 1'b0;
    check_first_init("ff_init");
    chk("ff_done_low", 32'(done), 32'd0);
    wait_done(1'b0, 1'b0, n, wr);
    chk("ff_latency", 32'(n), 32'd2048);
    check_mem("ff_final_s");
    step();
    chk("ff_done_hold", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
